tank_key_decoder: RTL
=====================

Name: tank_key_decoder

Overview:
- Sits directly downstream of the two 8-bit keycode PIO output ports (keycode0, keycode1) written by the NIOS USB keyboard driver.
- Samples both keycode bytes once per video frame and decodes USB HID usage codes into per-player tank movement levels and single-cycle fire pulses.
- Applies a per-player fire cooldown and direction-conflict resolution.
- Feeds the tank motion and bullet-spawn logic.

Parameters:
- FIRE_COOLDOWN, 15: frames after a shot during which further fire presses are ignored; range 0..255.
- CD_W, 8: cooldown counter width; must satisfy FIRE_COOLDOWN < 2**CD_W.

Ports:
- clk  in  1  system clock, same domain as the PIO slaves
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-clk pulse per frame (VSYNC start); the only sampling instant
- game_active  in  1  high while a round is in play
- keycode0  in  8  HID usage code from PIO slot 0; 0x00 means no key
- keycode1  in  8  HID usage code from PIO slot 1; 0x00 means no key
- p1_move  out  4  player 1 {fwd,back,left,right} levels
- p1_fire  out  1  player 1 fire pulse, one clk wide
- p2_move  out  4  player 2 {fwd,back,left,right} levels
- p2_fire  out  1  player 2 fire pulse, one clk wide

Behaviour:
- Reset:
  - All outputs 0.
  - Cooldown counters 0.
  - prev_fire flags 0.
- Sampling:
  - keycode inputs are ignored except in cycles where frame_tick=1.
  - Software writes between ticks have no effect until the next tick.
- Key map: a key is pressed if either keycode slot equals its code.
  - P1: fwd W=0x1A, back S=0x16, left A=0x04, right D=0x07, fire Q=0x14.
  - P2: fwd Up=0x52, back Down=0x51, left Left=0x50, right Right=0x4F, fire M=0x10.
- Conflicts:
  - fwd and back both pressed -> both 0.
  - left and right both pressed -> both 0.
  - Axes are resolved independently.
- Latency and hold:
  - Registered outputs update on the clk edge that samples frame_tick=1, so they are visible the following cycle.
  - p*_move holds until the next tick.
- Fire logic, per player, evaluated only on tick edges:
  - edge = fire_pressed & ~prev_fire.
  - prev_fire <= fire_pressed on every tick, including when game_active=0.
  - If cd != 0: cd <= cd-1, no fire.
  - Else if edge: p*_fire <= 1, cd <= FIRE_COOLDOWN.
  - Edges arriving during cooldown are dropped, not queued.
  - Minimum spacing between shots is FIRE_COOLDOWN+1 frames.
  - FIRE_COOLDOWN=0 allows one shot per press edge on consecutive ticks.
  - Holding the fire key never auto-repeats.
- Pulse width: p*_fire is cleared on the first non-tick edge, so it is exactly one clk wide. Back-to-back frame_tick pulses are illegal.
- game_active=0, sampled at tick:
  - move outputs 0, fire outputs 0, cd cleared to 0.
  - prev_fire still tracks, so a fire key held through round start does not fire.
- Same key in both slots: treated as a single press.
- Slot contents: unknown codes and 0x00 are ignored.
- Reset mid-frame: immediate clear; next tick behaves as first sample.
- The two players are fully independent, so simultaneous P1 and P2 fire can pulse in the same cycle.

Decomposition:
- Package tank_keys_pkg:
  - HID code localparams KEY_W/S/A/D/Q and KEY_UP/DOWN/LEFT/RIGHT/M.
  - move bit-index constants MV_FWD=3, MV_BACK=2, MV_LEFT=1, MV_RIGHT=0.
- Sub-module tank_key_player:
  - Inputs: key codes as parameters; keycode0/1, frame_tick, game_active.
  - Function: decode, conflict resolution, fire edge and cooldown.
  - Instantiated twice.
- Top level: wiring only.

Test Plan:
- Reset release, keycode0=0x1A, keycode1=0x00, tick -> p1_move=4'b1000 the cycle after the tick; p2_move=0; no fire. Changing keycode0 mid-frame leaves p1_move unchanged until the next tick.
- keycode0=0x1A, keycode1=0x16, tick -> p1_move=0. Then keycode1=0x04, tick -> p1_move=4'b1010.
- FIRE_COOLDOWN=3, Q held from tick 0 -> single p1_fire pulse after tick 0 only. Release and press Q again each frame -> pulses at ticks 0, 4, 8; presses at ticks 2 and 6 are dropped.
- P1 Q and P2 M pressed on the same tick (keycode0=0x14, keycode1=0x10) -> p1_fire and p2_fire both high for exactly 1 clk in the same cycle.
- game_active=0 with Q held across 3 ticks, then game_active=1 with Q still held -> no fire. After release then press -> one pulse.
- Assert reset_n low while cd=2 and p1_move=4'b0001 -> outputs 0 immediately. After release, Q pressed on the first tick fires immediately (cd was cleared).

Source files
------------

// File: rtl/tank_keys_pkg.sv
// tank_keys_pkg: shared constants for the tank keyboard decoder.
//   - USB HID usage codes for both players' movement and fire keys
//   - bit positions inside the 4-bit {fwd,back,left,right} move vector
package tank_keys_pkg;

    // Player 1: WASD + Q
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_Q     = 8'h14;

    // Player 2: arrow keys + M
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_M     = 8'h10;

    localparam int MV_FWD   = 3;
    localparam int MV_BACK  = 2;
    localparam int MV_LEFT  = 1;
    localparam int MV_RIGHT = 0;

endpackage

// File: rtl/tank_key_if.sv
// tank_key_if: bundles the keycode PIO side and the decoded tank controls.
//   master : drives frame_tick, game_active, keycode0/1; reads decoded outputs
//   slave  : the decoder; reads the keycodes, drives p1/p2 move and fire
interface tank_key_if;
    logic       frame_tick;
    logic       game_active;
    logic [7:0] keycode0;
    logic [7:0] keycode1;
    logic [3:0] p1_move;
    logic       p1_fire;
    logic [3:0] p2_move;
    logic       p2_fire;

    modport master (
        output frame_tick, game_active, keycode0, keycode1,
        input  p1_move, p1_fire, p2_move, p2_fire
    );

    modport slave (
        input  frame_tick, game_active, keycode0, keycode1,
        output p1_move, p1_fire, p2_move, p2_fire
    );
endinterface

// File: rtl/tank_key_player.sv
// tank_key_player: per-player decode of the two keycode slots.
//   Samples only when frame_tick=1. Produces registered move levels
//   ({fwd,back,left,right}, opposing keys cancel per axis) and a one-clk
//   fire pulse gated by a press-edge detector and a frame cooldown.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   frame_tick            one-clk per-frame sample strobe
//   game_active           round in play; low forces outputs/cooldown to 0
//   keycode0, keycode1    HID usage codes from the PIO slots
//   move, fire            decoded outputs
module tank_key_player
    import tank_keys_pkg::*;
#(
    parameter logic [7:0] K_FWD         = KEY_W,
    parameter logic [7:0] K_BACK        = KEY_S,
    parameter logic [7:0] K_LEFT        = KEY_A,
    parameter logic [7:0] K_RIGHT       = KEY_D,
    parameter logic [7:0] K_FIRE        = KEY_Q,
    parameter int         FIRE_COOLDOWN = 15,
    parameter int         CD_W          = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       game_active,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [3:0] move,
    output logic       fire
);

    logic            fwd_p, back_p, left_p, right_p, fire_p;
    logic [3:0]      move_next;
    logic            prev_fire;
    logic [CD_W-1:0] cd;

    // A key in both slots is still just one press; 0x00 never matches.
    assign fwd_p   = (keycode0 == K_FWD)   || (keycode1 == K_FWD);
    assign back_p  = (keycode0 == K_BACK)  || (keycode1 == K_BACK);
    assign left_p  = (keycode0 == K_LEFT)  || (keycode1 == K_LEFT);
    assign right_p = (keycode0 == K_RIGHT) || (keycode1 == K_RIGHT);
    assign fire_p  = (keycode0 == K_FIRE)  || (keycode1 == K_FIRE);

    always_comb begin
        move_next           = '0;
        move_next[MV_FWD]   = fwd_p   & ~back_p;
        move_next[MV_BACK]  = back_p  & ~fwd_p;
        move_next[MV_LEFT]  = left_p  & ~right_p;
        move_next[MV_RIGHT] = right_p & ~left_p;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            move      <= '0;
            fire      <= 1'b0;
            cd        <= '0;
            prev_fire <= 1'b0;
        end else begin
            // Default clear keeps fire one clk wide (ticks are never adjacent).
            fire <= 1'b0;
            if (frame_tick) begin
                // Tracks even outside a round so a held key can't fire at start.
                prev_fire <= fire_p;
                if (!game_active) begin
                    move <= '0;
                    cd   <= '0;
                end else begin
                    move <= move_next;
                    if (cd != '0) begin
                        cd <= cd - CD_W'(1);
                    end else if (fire_p && !prev_fire) begin
                        fire <= 1'b1;
                        cd   <= CD_W'(FIRE_COOLDOWN);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tank_key_decoder.sv
// tank_key_decoder: frame-sampled keyboard decoder for two tank players.
//   Wiring only: one tank_key_player per player, keyed by its HID codes.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   bus (slave)    frame_tick, game_active, keycode0/1 in;
//                  p1_move, p1_fire, p2_move, p2_fire out
module tank_key_decoder
    import tank_keys_pkg::*;
#(
    parameter int FIRE_COOLDOWN = 15,
    parameter int CD_W          = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    tank_key_if.slave  bus
);

    tank_key_player #(
        .K_FWD(KEY_W), .K_BACK(KEY_S), .K_LEFT(KEY_A), .K_RIGHT(KEY_D),
        .K_FIRE(KEY_Q), .FIRE_COOLDOWN(FIRE_COOLDOWN), .CD_W(CD_W)
    ) u_p1 (
        .clk(clk), .reset_n(reset_n),
        .frame_tick(bus.frame_tick), .game_active(bus.game_active),
        .keycode0(bus.keycode0), .keycode1(bus.keycode1),
        .move(bus.p1_move), .fire(bus.p1_fire)
    );

    tank_key_player #(
        .K_FWD(KEY_UP), .K_BACK(KEY_DOWN), .K_LEFT(KEY_LEFT), .K_RIGHT(KEY_RIGHT),
        .K_FIRE(KEY_M), .FIRE_COOLDOWN(FIRE_COOLDOWN), .CD_W(CD_W)
    ) u_p2 (
        .clk(clk), .reset_n(reset_n),
        .frame_tick(bus.frame_tick), .game_active(bus.game_active),
        .keycode0(bus.keycode0), .keycode1(bus.keycode1),
        .move(bus.p2_move), .fire(bus.p2_fire)
    );

endmodule
